acc_issue: RTL and testbench
============================

ACC_ISSUE -- requirements
Module: acc_issue

Interface
REQ-001 Parameters SHALL be, one per line: DN, 6, number of lanes; PSW, 16, signed partial-sum width per lane; DW, 22, signed accumulator width per lane; MULW, 9, scale multiplier width; CW2, 7, tag width; NE, 8, parameter-table entries.
REQ-002 Ports SHALL be, one per line: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-003 in_data  in  DN*PSW  signed partial sums; lane i = in_data[i*PSW +: PSW].
REQ-004 in_valid  in  1  beat valid.
REQ-005 in_last  in  1  final beat of frame; qualified by in_valid.
REQ-006 in_grp  in  3  parameter-table index; sampled on a frame's first beat.
REQ-007 in_tag  in  CW2  pass-through tag; sampled on a frame's first beat.
REQ-008 cfg_we  in  1  table write strobe.
REQ-009 cfg_addr  in  3  table write index.
REQ-010 cfg_wdata  in  16  entry: [8:0] mul, [13:9] n, [15:14] relu_en.
REQ-011 cfg_clr_sat  in  1  clears sat_flag.
REQ-012 m_data1  out  DN*DW  accumulated result; lane i = m_data1[i*DW +: DW].
REQ-013 m_valid1  out  1  result valid, one-cycle pulse per frame.
REQ-014 m_ctrl  out  23  {tag[6:0], relu_en[1:0], n[4:0], mul[8:0]}, bits [22:16], [15:14], [13:9], [8:0].
REQ-015 sat_flag  out  1  sticky: some lane saturated.

Function
REQ-016 No back-pressure: every in_valid beat SHALL be accepted; the downstream consumes m_valid1 unconditionally.
REQ-017 FSM states SHALL be IDLE (no frame open) and ACC (frame open).
- IDLE, in_valid & !in_last: first beat, capture grp/tag, go ACC.
- IDLE, in_valid & in_last: single-beat frame, emit, stay IDLE.
- ACC, in_valid & !in_last: accumulate, stay ACC.
- ACC, in_valid & in_last: emit, go IDLE.
- No in_valid: hold state and accumulator.
REQ-018 Per lane: sum = acc + sign-extended in_data, computed in DW+1 bits, clipped to [-2^21, 2^21-1]. On the first beat, acc SHALL be treated as 0.
REQ-019 Any lane clipping on any accepted beat SHALL set sat_flag on the next cycle. sat_flag SHALL hold until cfg_clr_sat. If clear and set occur in the same cycle, set wins.
REQ-020 Emit: in the cycle after the last beat is accepted, m_data1 SHALL equal the clipped final sums and m_valid1 SHALL be 1. The accumulator SHALL be cleared at the same edge. Latency from last beat to m_valid1 = 1 cycle.
REQ-021 m_data1 and m_ctrl SHALL hold their value until the next emit. m_valid1 SHALL be 0 in every non-emit cycle.
REQ-022 Back-to-back frames SHALL be supported: a first beat in the cycle following a last beat starts a new frame with no bubble. Frames of one beat each SHALL give m_valid1 every cycle.
REQ-023 m_ctrl mul/n/relu_en SHALL come from table[grp] as read in the last-beat cycle, where grp is the value captured at the first beat. The tag SHALL be the value captured at the first beat. For a single-beat frame, in_grp and in_tag are used directly.
REQ-024 A table write to the entry being read in the same cycle SHALL return the old value; the new value is visible from the next cycle.
REQ-025 cfg_we SHALL update table[cfg_addr] at the clock edge, independent of FSM state.
REQ-026 in_last without in_valid SHALL be ignored.

Reset
REQ-027 While rst_n=0 at a clk edge: state SHALL become IDLE; accumulator, all table entries, m_data1, m_ctrl and sat_flag SHALL become 0; m_valid1 SHALL become 0.
REQ-028 Reset during an open frame SHALL discard the partial sums, and no m_valid1 SHALL be produced for that frame.
REQ-029 The first beat after reset release SHALL start a new frame.

Verification
REQ-030 Table[2]=0xA345 (mul=0x145, n=17, relu=2). Frame grp=2, tag=0x15, 3 beats with lane0 = 100, -30, 7 -> one cycle after beat 3: m_valid1=1, lane0=77, m_ctrl={0x15,2'b10,5'd17,9'h145}.
REQ-031 Beats with lane0=0x7FFF repeated 70 times -> lane0=2097151 (0x1FFFFF), sat_flag=1. Then cfg_clr_sat -> sat_flag=0 next cycle.
REQ-032 Single-beat frames on 4 consecutive cycles with lane3 = -1, -2, -3, -4 -> m_valid1 high for 4 consecutive cycles, lane3 = -1, -2, -3, -4, each with its own tag.
REQ-033 cfg_we to table[1] in the same cycle as the last beat of a grp=1 frame -> old entry in m_ctrl. Next grp=1 frame -> new entry.
REQ-034 rst_n low for 1 cycle after beat 2 of a 4-beat frame, then 2 fresh beats (5, 6, last) -> lane0=11, exactly one m_valid1 pulse, m_ctrl mul/n/relu=0.
REQ-035 Idle gaps (in_valid=0 for 5 cycles) between beats of a frame -> sum unchanged, correct single emit.

Source files
------------

// File: rtl/acc_issue.sv
// acc_issue: per-lane frame accumulator with saturation, parameter-table lookup and tagged result
module acc_issue #(
  parameter int DN   = 6,
  parameter int PSW  = 16,
  parameter int DW   = 22,
  parameter int MULW = 9,
  parameter int CW2  = 7,
  parameter int NE   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DN*PSW-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [2:0]          in_grp,
  input  logic [CW2-1:0]      in_tag,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [15:0]         cfg_wdata,
  input  logic                cfg_clr_sat,
  output logic [DN*DW-1:0]    m_data1,
  output logic                m_valid1,
  output logic [CW2+15:0]     m_ctrl,
  output logic                sat_flag
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t st, st_n;
  logic [DN*DW-1:0] acc, sat_sum;
  logic [DN-1:0] clip;
  logic [15:0] tbl [NE];
  logic [2:0] grp_q, grp_s;
  logic [CW2-1:0] tag_q, tag_s;
  logic first, emit;
  assign first = in_valid && st == IDLE;
  assign emit  = in_valid && in_last;
  assign grp_s = st == IDLE ? in_grp : grp_q;
  assign tag_s = st == IDLE ? in_tag : tag_q;
  for (genvar i = 0; i < DN; i++) begin : g_lane
    logic [DW:0] sum;
    assign sum = (st == ACC ? {acc[i*DW+DW-1], acc[i*DW +: DW]} : '0)
               + {{(DW+1-PSW){in_data[i*PSW+PSW-1]}}, in_data[i*PSW +: PSW]};
    assign clip[i] = sum[DW] ^ sum[DW-1];
    assign sat_sum[i*DW +: DW] = clip[i] ? {sum[DW], {(DW-1){~sum[DW]}}} : sum[DW-1:0];
  end
  // next state: any accepted beat opens a frame unless it is the last one
  always_comb begin
    st_n = in_valid ? (in_last ? IDLE : ACC) : st;
  end
  // state, accumulator, frame context captured on the first beat, sticky saturation (set beats clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      acc      <= '0;
      grp_q    <= '0;
      tag_q    <= '0;
      sat_flag <= 1'b0;
    end else begin
      st <= st_n;
      if (in_valid) acc <= in_last ? '0 : sat_sum;
      if (first) begin
        grp_q <= in_grp;
        tag_q <= in_tag;
      end
      sat_flag <= (in_valid && |clip) || (sat_flag && !cfg_clr_sat);
    end
  end
  // parameter table; a same-cycle read sees the old entry
  always_ff @(posedge clk) begin
    if (!rst_n) for (int k = 0; k < NE; k++) tbl[k] <= '0;
    else if (cfg_we) tbl[cfg_addr] <= cfg_wdata;
  end
  // result registers: pulse valid, hold data/ctrl until the next emit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data1  <= '0;
      m_ctrl   <= '0;
      m_valid1 <= 1'b0;
    end else begin
      m_valid1 <= emit;
      if (emit) begin
        m_data1 <= sat_sum;
        m_ctrl  <= {tag_s, tbl[grp_s][15:MULW], tbl[grp_s][MULW-1:0]};
      end
    end
  end
endmodule

// File: tb/tb_acc_issue.sv
// tb_acc_issue: directed stimulus with a reference model feeding a result scoreboard
module tb_acc_issue;
  localparam int DN = 6, PSW = 16, DW = 22, CW2 = 7;
  localparam longint SMAX = 2097151, SMIN = -2097152;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DN*PSW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [2:0] in_grp = '0;
  logic [CW2-1:0] in_tag = '0;
  logic cfg_we = 1'b0, cfg_clr_sat = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [DN*DW-1:0] m_data1;
  logic m_valid1, sat_flag;
  logic [CW2+15:0] m_ctrl;
  typedef struct {
    logic [DN*DW-1:0] d;
    logic [CW2+15:0]  c;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, pulses = 0, pushes = 0;
  longint macc[DN];
  bit mopen = 0, msat = 0;
  logic [2:0] mgrp = '0;
  logic [CW2-1:0] mtag = '0;
  logic [15:0] mtbl[8];

  always #5 clk = ~clk;

  acc_issue dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_grp(in_grp), .in_tag(in_tag), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_clr_sat(cfg_clr_sat), .m_data1(m_data1),
    .m_valid1(m_valid1), .m_ctrl(m_ctrl), .sat_flag(sat_flag)
  );

  task automatic chk(input string tag, input logic [DN*DW-1:0] obs, input logic [DN*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, then check valid/sat and drain the scoreboard on a pulse
  task automatic tick(input bit exp_valid);
    exp_t e;
    @(posedge clk);
    #1;
    chk("m_valid1", m_valid1, exp_valid);
    chk("sat_flag", sat_flag, msat);
    if (m_valid1 === 1'b1) begin
      pulses++;
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_pulse: observed m_valid1=1 expected 0");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_data", m_data1, e.d);
        chk("sb_ctrl", m_ctrl, e.c);
      end
    end
    cfg_we = 1'b0;
    cfg_clr_sat = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // one cycle of stimulus; lane0=l0, lane3=l3, other lanes l0-i
  task automatic beat(input bit v, input bit last, input int l0, input int l3,
                      input logic [2:0] g, input logic [CW2-1:0] t);
    int lane[DN];
    bit set;
    exp_t e;
    set = 0;
    for (int i = 0; i < DN; i++) lane[i] = (i == 3) ? l3 : l0 - i;
    in_valid = v;
    in_last = last;
    in_grp = g;
    in_tag = t;
    for (int i = 0; i < DN; i++) in_data[i*PSW +: PSW] = 16'(lane[i]);
    if (v) begin
      if (!mopen) begin
        for (int i = 0; i < DN; i++) macc[i] = 0;
        mgrp = g;
        mtag = t;
      end
      for (int i = 0; i < DN; i++) begin
        macc[i] += lane[i];
        if (macc[i] > SMAX) begin macc[i] = SMAX; set = 1; end
        if (macc[i] < SMIN) begin macc[i] = SMIN; set = 1; end
      end
      if (last) begin
        for (int i = 0; i < DN; i++) e.d[i*DW +: DW] = DW'(macc[i]);
        e.c = {mtag, mtbl[mgrp]};
        sb.push_back(e);
        pushes++;
        mopen = 0;
      end else mopen = 1;
    end
    msat = set || (msat && !cfg_clr_sat);
    if (cfg_we) mtbl[cfg_addr] = cfg_wdata;
    tick(v && last);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(0, 1, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    idle(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mopen = 0;
    msat = 0;
    for (int i = 0; i < 8; i++) mtbl[i] = '0;
    tick(0);
    rst_n = 1'b1;
    chk("rst_data", m_data1, '0);
    chk("rst_ctrl", m_ctrl, '0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mtbl[i] = '0;
    tick(0);
    do_reset();
    wr(3'd2, 16'hA345);
    wr(3'd1, 16'h0123);
    beat(1, 0, 100, 5, 3'd2, 7'h15);
    beat(1, 0, -30, -7, 3'd0, 7'h00);
    beat(1, 1, 7, 9, 3'd0, 7'h00);
    chk("r30_lane0", m_data1[DW-1:0], 22'd77);
    chk("r30_ctrl", m_ctrl, {7'h15, 2'b10, 5'd17, 9'h145});
    beat(1, 0, 10, 1, 3'd1, 7'h03);
    idle(5);
    beat(1, 0, 20, 2, 3'd5, 7'h11);
    idle(5);
    beat(1, 1, 30, 3, 3'd6, 7'h22);
    chk("gap_lane0", m_data1[DW-1:0], 22'd60);
    chk("gap_ctrl", m_ctrl, {7'h03, 16'h0123});
    beat(1, 1, 1, -1, 3'd2, 7'h41);
    beat(1, 1, 2, -2, 3'd1, 7'h42);
    beat(1, 1, 3, -3, 3'd0, 7'h43);
    beat(1, 1, 4, -4, 3'd2, 7'h44);
    chk("b2b_lane3", m_data1[3*DW +: DW], 22'h3FFFFC);
    chk("b2b_tag", m_ctrl[22:16], 7'h44);
    for (int k = 0; k < 69; k++) beat(1, 0, 32767, -32768, 3'd0, 7'h7F);
    cfg_clr_sat = 1'b1;
    beat(1, 1, 32767, -32768, 3'd0, 7'h7F);
    chk("sat_lane0", m_data1[DW-1:0], 22'h1FFFFF);
    chk("sat_lane3", m_data1[3*DW +: DW], 22'h200000);
    chk("sat_set_wins", sat_flag, 1'b1);
    cfg_clr_sat = 1'b1;
    idle(1);
    chk("sat_cleared", sat_flag, 1'b0);
    beat(1, 0, 50, 1, 3'd1, 7'h09);
    cfg_we = 1'b1;
    cfg_addr = 3'd1;
    cfg_wdata = 16'hBEEF;
    beat(1, 1, 60, 1, 3'd1, 7'h09);
    chk("wr_old", m_ctrl[15:0], 16'h0123);
    beat(1, 1, 70, 1, 3'd1, 7'h0A);
    chk("wr_new", m_ctrl[15:0], 16'hBEEF);
    beat(1, 0, 1000, 1, 3'd2, 7'h33);
    beat(1, 0, 2000, 1, 3'd2, 7'h33);
    do_reset();
    beat(1, 0, 5, 1, 3'd2, 7'h2C);
    beat(1, 1, 6, 1, 3'd2, 7'h2C);
    chk("rstf_lane0", m_data1[DW-1:0], 22'd11);
    chk("rstf_ctrl", m_ctrl[15:0], 16'h0000);
    idle(3);
    chk("sb_drained", sb.size(), 0);
    chk("pulse_count", pulses, pushes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
